// File: rtl/kron_operand_loader.sv
// kron_operand_loader
//
// Collects matrix elements arriving one word per beat (all of A, then all of
// B, both row-major) and presents them as the packed A/B vectors consumed by
// the combinational Kronecker product stage. A completed pair is held stable
// under an output valid/ready handshake; malformed frames are discarded and
// reported with a one-cycle frame_err pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data carries an element
//   in_ready   loader accepts an element this cycle (combinational)
//   in_data    element value, word_size bits
//   in_last    marks the final B element of a frame
//   out_valid  A and B hold a complete frame
//   out_ready  downstream takes the frame
//   A          packed A, element (0,0) in the MSBs
//   B          packed B, element (0,0) in the MSBs
//   frame_err  one-cycle pulse when a frame is discarded
module kron_operand_loader #(
    parameter int word_size     = 32,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [word_size-1:0]                                 in_data,
    input  logic                                                 in_last,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]     A,
    output logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0]     B,
    output logic                                                 frame_err
);

    localparam int NA   = Amatrixrownum * Amatrixcolnum;
    localparam int NB   = Bmatrixrownum * Bmatrixcolnum;
    localparam int NMAX = (NA > NB) ? NA : NB;
    localparam int IW   = $clog2(NMAX + 1);

    localparam logic [IW-1:0] A_LAST = IW'(NA - 1);
    localparam logic [IW-1:0] B_LAST = IW'(NB - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            err_reg, err_next;
    logic            accept;
    logic            wr_a;
    logic            wr_b;

    // in_ready is the only combinational output; it is held low during reset
    // so nothing is accepted while the loader is being cleared.
    assign in_ready  = ~rst && (state_reg != HOLD);
    assign accept    = in_valid && in_ready;
    assign wr_a      = accept && (state_reg == LOAD_A);
    assign wr_b      = accept && (state_reg == LOAD_B);
    assign out_valid = (state_reg == HOLD);
    assign frame_err = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD_A;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        err_next   = 1'b0;
        case (state_reg)
            LOAD_A: begin
                if (accept) begin
                    if (in_last) begin
                        // in_last is never legal while loading A
                        err_next   = 1'b1;
                        state_next = LOAD_A;
                        idx_next   = '0;
                    end else if (idx_reg == A_LAST) begin
                        state_next = LOAD_B;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (idx_reg == B_LAST) begin
                        // final B slot must carry in_last, otherwise discard
                        state_next = in_last ? HOLD : LOAD_A;
                        err_next   = ~in_last;
                        idx_next   = '0;
                    end else if (in_last) begin
                        err_next   = 1'b1;
                        state_next = LOAD_A;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = LOAD_A;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = LOAD_A;
                idx_next   = '0;
            end
        endcase
    end

    // One register per element slot. Slots are only written from the input
    // side, so A/B are frozen for as long as the FSM sits in HOLD.
    genvar gi;
    generate
        for (gi = 0; gi < NA; gi++) begin : g_a_slot
            logic [word_size-1:0] slot_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (wr_a && (idx_reg == IW'(gi))) begin
                    slot_reg <= in_data;
                end
            end
            assign A[NA*word_size-1-gi*word_size -: word_size] = slot_reg;
        end

        for (gi = 0; gi < NB; gi++) begin : g_b_slot
            logic [word_size-1:0] slot_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (wr_b && (idx_reg == IW'(gi))) begin
                    slot_reg <= in_data;
                end
            end
            assign B[NB*word_size-1-gi*word_size -: word_size] = slot_reg;
        end
    endgenerate

endmodule

// File: tb/tb_kron_operand_loader.sv
// Testbench for kron_operand_loader (2x2 / 2x2, 32-bit words).
// Drives directed and randomised frames; expected A/B vectors and handshake
// outcomes are computed from the frame contents with plain arithmetic.
module tb_kron_operand_loader;

    localparam int W  = 32;
    localparam int NA = 4;
    localparam int NB = 4;
    localparam int NF = NA + NB;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [NA*W-1:0]     A;
    logic [NB*W-1:0]     B;
    logic                frame_err;

    int n_checks;
    int n_fails;

    logic [W-1:0] fd [NF];

    kron_operand_loader #(
        .word_size     (W),
        .Amatrixrownum (2),
        .Amatrixcolnum (2),
        .Bmatrixrownum (2),
        .Bmatrixcolnum (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [127:0] pack_a();
        logic [127:0] v = '0;
        for (int i = 0; i < NA; i++) v = (v << W) | 128'(fd[i]);
        return v;
    endfunction

    function automatic logic [127:0] pack_b();
        logic [127:0] v = '0;
        for (int i = 0; i < NB; i++) v = (v << W) | 128'(fd[NA + i]);
        return v;
    endfunction

    // Present one beat after some idle cycles; returns #1 after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input bit last, input int bubble);
        in_valid = 1'b0;
        repeat (bubble) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends nbeats of fd[], in_last on beat last_pos (-1 = never), then checks
    // the frame outcome. A frame is clean only when all NF beats are sent and
    // in_last is on exactly the final one.
    task automatic run_frame(input string tag, input int nbeats, input int last_pos,
                             input bit bubbles, input int hold_cycles);
        bit clean;
        logic [127:0] ea, eb;
        clean = (nbeats == NF) && (last_pos == NF - 1);
        for (int i = 0; i < nbeats; i++)
            send_beat(fd[i], (i == last_pos), bubbles ? int'($urandom_range(0, 2)) : 0);
        if (clean) begin
            ea = pack_a();
            eb = pack_b();
            check({tag, "_out_valid"}, 128'(out_valid), 1);
            check({tag, "_frame_err"}, 128'(frame_err), 0);
            check({tag, "_A"}, A, ea);
            check({tag, "_B"}, B, eb);
            check({tag, "_in_ready_hold"}, 128'(in_ready), 0);
            out_ready = 1'b0;
            for (int c = 0; c < hold_cycles; c++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 128'(out_valid), 1);
                check({tag, "_hold_ready"}, 128'(in_ready), 0);
                check({tag, "_hold_AB"}, {A[63:0], B[63:0]}, {ea[63:0], eb[63:0]});
            end
            out_ready = 1'b1;
            check({tag, "_no_bypass"}, 128'(in_ready), 0);
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_valid_drop"}, 128'(out_valid), 0);
            check({tag, "_ready_back"}, 128'(in_ready), 1);
        end else begin
            check({tag, "_err_pulse"}, 128'(frame_err), 1);
            check({tag, "_no_valid"}, 128'(out_valid), 0);
            @(posedge clk); #1;
            check({tag, "_err_single"}, 128'(frame_err), 0);
            check({tag, "_no_valid2"}, 128'(out_valid), 0);
            check({tag, "_load_a_ready"}, 128'(in_ready), 1);
        end
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < NF; i++) fd[i] = W'(base + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NF; i++) fd[i] = $urandom;
    endtask

    task automatic do_reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_valid"}, 128'(out_valid), 0);
        check({tag, "_A"}, A, 0);
        check({tag, "_B"}, B, 0);
        check({tag, "_in_ready"}, 128'(in_ready), 0);
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;
        check({tag, "_release"}, 128'(in_ready), 1);
    endtask

    logic [W-1:0] stream [3*NF];
    int           rise_cyc [$];
    int           hi_count;

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #3;
        check("rst_in_ready", 128'(in_ready), 0);
        check("rst_out_valid", 128'(out_valid), 0);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_frame_err", 128'(frame_err), 0);
        @(posedge clk);
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 128'(in_ready), 1);

        // Clean frame 1..8
        fill_seq(1);
        run_frame("clean", NF, NF - 1, 1'b0, 0);
        check("tp_top_word", 128'(32'(A[127:96] * B[127:96])), 5);

        // Same frame with bubbles and 5 stalled HOLD cycles
        run_frame("bubble", NF, NF - 1, 1'b1, 5);

        // Early in_last on A element 3, then clean 9..16
        fill_seq(1);
        run_frame("early_last", 3, 2, 1'b0, 0);
        fill_seq(9);
        run_frame("after_err", NF, NF - 1, 1'b0, 0);
        check("after_err_A_const", A, 128'h00000009_0000000A_0000000B_0000000C);

        // Missing in_last on 8th beat, then a clean random frame
        fill_seq(1);
        run_frame("missing_last", NF, -1, 1'b0, 0);
        fill_rand();
        run_frame("after_missing", NF, NF - 1, 1'b1, 0);

        // Reset mid LOAD_B
        fill_rand();
        for (int i = 0; i < 5; i++) send_beat(fd[i], 1'b0, 0);
        do_reset_pulse("rst_load_b");
        fill_rand();
        run_frame("after_rst_b", NF, NF - 1, 1'b0, 0);

        // Reset during HOLD
        fill_rand();
        for (int i = 0; i < NF; i++) send_beat(fd[i], (i == NF - 1), 0);
        check("hold_before_rst", 128'(out_valid), 1);
        do_reset_pulse("rst_hold");
        fill_rand();
        run_frame("after_rst_hold", NF, NF - 1, 1'b1, 2);

        // Randomised mix of clean and malformed frames
        for (int f = 0; f < 12; f++) begin
            int kind;
            int p;
            fill_rand();
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                p = int'($urandom_range(0, NF - 2));
                run_frame("rand_early", p + 1, p, 1'b1, 0);
            end else if (kind == 1) begin
                run_frame("rand_missing", NF, -1, 1'b1, 0);
            end else begin
                run_frame("rand_clean", NF, NF - 1, 1'b1, int'($urandom_range(0, 3)));
            end
        end

        // Back-to-back frames, out_ready tied high, continuous in_valid
        for (int i = 0; i < 3 * NF; i++) stream[i] = $urandom;
        out_ready = 1'b1;
        hi_count  = 0;
        begin
            int ptr;
            ptr = 0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (out_valid) begin
                    logic [127:0] ea, eb;
                    int fr;
                    fr = hi_count;
                    ea = '0;
                    eb = '0;
                    for (int k = 0; k < NA; k++) ea = (ea << W) | 128'(stream[fr*NF + k]);
                    for (int k = 0; k < NB; k++) eb = (eb << W) | 128'(stream[fr*NF + NA + k]);
                    if (fr < 3) begin
                        check("b2b_A", A, ea);
                        check("b2b_B", B, eb);
                    end
                    rise_cyc.push_back(cyc);
                    hi_count++;
                end
                if (ptr < 3 * NF) begin
                    in_valid = 1'b1;
                    in_data  = stream[ptr];
                    in_last  = ((ptr % NF) == NF - 1);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                if (in_valid && in_ready) ptr++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        check("b2b_valid_cycles", 128'(hi_count), 3);
        if (rise_cyc.size() >= 3) begin
            check("b2b_period_1", 128'(rise_cyc[1] - rise_cyc[0]), NF + 1);
            check("b2b_period_2", 128'(rise_cyc[2] - rise_cyc[1]), NF + 1);
        end else begin
            check("b2b_rise_count", 128'(rise_cyc.size()), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
